hex_counter_display: RTL and testbench

- Parametrised multi-digit counter with a seven-segment driver for the DE10-Lite HEX displays.
- Generalises the single-digit 4-bit→HEX0 decoder into a free-running, clock-prescaled counter of DIGITS nibbles.
- Adds hex/BCD modes, up/down counting, synchronous load, wrap flag and leading-zero blanking.
- Sits between board switches/keys and the HEX outputs in top-level board labs.

---
 rtl/hex_counter_display_if.sv | 29 ++
 rtl/hex_counter_display.sv | 109 ++++++++++
 tb/tb_hex_counter_display.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/hex_counter_display_if.sv
// Control and display bus of the multi-digit hex/BCD counter.
// The master drives the controls and the slave drives the count and the segments.
interface hex_counter_display_if #(
  parameter int unsigned DIGITS = 6
);
  localparam int unsigned VW = 4 * DIGITS;
  localparam int unsigned HW = 8 * DIGITS;

  logic          en;
  logic          up;
  logic          load;
  logic [VW-1:0] load_val;
  logic          bcd_mode;
  logic          blank_lz;
  logic [VW-1:0] value;
  logic          tick;
  logic          wrap;
  logic [HW-1:0] hex_out;

  modport master (
    output en, up, load, load_val, bcd_mode, blank_lz,
    input  value, tick, wrap, hex_out
  );

  modport slave (
    input  en, up, load, load_val, bcd_mode, blank_lz,
    output value, tick, wrap, hex_out
  );
endinterface

// File: rtl/hex_counter_display.sv
// Prescaled multi-digit up/down counter (hex or BCD) with a registered,
// active-low seven-segment driver and optional leading-zero blanking.
module hex_counter_display #(
  parameter int unsigned DIGITS = 6,
  parameter int unsigned DIV    = 50000000,
  parameter int unsigned DIV_W  = 26
) (
  input  logic                  clk,
  input  logic                  rst,
  hex_counter_display_if.slave  bus
);
  localparam int unsigned VW = 4 * DIGITS;
  localparam int unsigned HW = 8 * DIGITS;

  logic [DIV_W-1:0] presc;
  logic             tick_c;
  logic [VW-1:0]    step_c;
  logic             carry_c;
  logic [VW-1:0]    load_c;
  logic [HW-1:0]    seg_c;
  logic [3:0]       dmax_c;
  logic [3:0]       sdig_c;
  logic             cy_c;
  logic [3:0]       ddig_c;
  logic             nz_c;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'h0: s = 8'hC0;  4'h1: s = 8'hF9;  4'h2: s = 8'hA4;  4'h3: s = 8'hB0;
      4'h4: s = 8'h99;  4'h5: s = 8'h92;  4'h6: s = 8'h82;  4'h7: s = 8'hF8;
      4'h8: s = 8'h80;  4'h9: s = 8'h90;  4'hA: s = 8'h88;  4'hB: s = 8'h83;
      4'hC: s = 8'hC6;  4'hD: s = 8'hA1;  4'hE: s = 8'h86;  default: s = 8'h8E;
    endcase
    return s;
  endfunction

  assign tick_c = bus.en && !bus.load && (presc == DIV_W'(DIV - 1));
  assign dmax_c = bus.bcd_mode ? 4'd9 : 4'hF;

  // Ripple carry/borrow step; in BCD mode digits above 9 act as 9
  always_comb begin
    step_c = '0;
    cy_c   = 1'b1;
    sdig_c = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      sdig_c = bus.value[4*i +: 4];
      if (bus.bcd_mode && sdig_c > 4'd9) sdig_c = 4'd9;
      if (cy_c) begin
        if (bus.up) begin
          if (sdig_c == dmax_c) sdig_c = 4'd0;
          else begin
            sdig_c = sdig_c + 4'd1;
            cy_c   = 1'b0;
          end
        end else begin
          if (sdig_c == 4'd0) sdig_c = dmax_c;
          else begin
            sdig_c = sdig_c - 4'd1;
            cy_c   = 1'b0;
          end
        end
      end
      step_c[4*i +: 4] = sdig_c;
    end
    carry_c = cy_c;
  end

  always_comb begin
    load_c = bus.load_val;
    for (int i = 0; i < int'(DIGITS); i++)
      if (bus.bcd_mode && bus.load_val[4*i +: 4] > 4'd9) load_c[4*i +: 4] = 4'd9;
  end

  // Decode from the top digit down so leading zeros can be blanked
  always_comb begin
    seg_c  = '0;
    nz_c   = 1'b0;
    ddig_c = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      ddig_c = bus.value[4*i +: 4];
      nz_c   = nz_c | (ddig_c != 4'd0);
      if (bus.blank_lz && !nz_c && i != 0)        seg_c[8*i +: 8] = 8'hFF;
      else if (bus.bcd_mode && ddig_c > 4'd9)     seg_c[8*i +: 8] = 8'h90;
      else                                        seg_c[8*i +: 8] = seg7(ddig_c);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc       <= '0;
      bus.value   <= '0;
      bus.tick    <= 1'b0;
      bus.wrap    <= 1'b0;
      bus.hex_out <= {DIGITS{8'hC0}};
    end else begin
      if (bus.load)     presc <= '0;
      else if (tick_c)  presc <= '0;
      else if (bus.en)  presc <= presc + DIV_W'(1);

      if (bus.load)     bus.value <= load_c;
      else if (tick_c)  bus.value <= step_c;

      bus.tick    <= tick_c;
      bus.wrap    <= tick_c && carry_c;
      bus.hex_out <= seg_c;
    end
  end
endmodule

// File: tb/tb_hex_counter_display.sv
// Directed bench for hex_counter_display with DIGITS=2, DIV=4.
module tb_hex_counter_display;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   passed = 0;
  int   total  = 0;

  hex_counter_display_if #(.DIGITS(2)) bus ();

  hex_counter_display #(.DIGITS(2), .DIV(4), .DIV_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input string tag);
    int n = 0;
    do begin
      step();
      n++;
    end while (bus.tick !== 1'b1 && n < 10);
    chk(tag, 32'(bus.tick), 32'h1);
  endtask

  task automatic do_load(input logic [7:0] v);
    bus.load     = 1'b1;
    bus.load_val = v;
    step();
    bus.load     = 1'b0;
  endtask

  initial begin
    bus.en = 1'b0; bus.up = 1'b1; bus.load = 1'b0; bus.load_val = 8'h00;
    bus.bcd_mode = 1'b0; bus.blank_lz = 1'b0;

    // Reset state
    #12;
    chk("rst_value", 32'(bus.value), 32'h00);
    chk("rst_tick", 32'(bus.tick), 32'h0);
    chk("rst_wrap", 32'(bus.wrap), 32'h0);
    chk("rst_hex", 32'(bus.hex_out), 32'hC0C0);
    step();
    rst = 1'b0;
    bus.en = 1'b1;

    // Tick on every 4th clock, value 04 after four ticks, 1-cycle display lag
    for (int i = 1; i <= 16; i++) begin
      step();
      chk("tick_period", 32'(bus.tick), (i % 4 == 0) ? 32'h1 : 32'h0);
    end
    chk("count4_value", 32'(bus.value), 32'h04);
    chk("count4_hex_lag", 32'(bus.hex_out), 32'hC0B0);
    step();
    chk("count4_hex", 32'(bus.hex_out), 32'hC099);
    chk("tick_one_cycle", 32'(bus.tick), 32'h0);

    // Hex wrap FE -> FF -> 00
    do_load(8'hFE);
    chk("load_fe", 32'(bus.value), 32'hFE);
    chk("load_fe_tick", 32'(bus.tick), 32'h0);
    wait_tick("tick_ff");
    chk("val_ff", 32'(bus.value), 32'hFF);
    chk("wrap_ff", 32'(bus.wrap), 32'h0);
    step();
    chk("hex_ff", 32'(bus.hex_out), 32'h8E8E);
    wait_tick("tick_00");
    chk("val_00", 32'(bus.value), 32'h00);
    chk("wrap_00", 32'(bus.wrap), 32'h1);
    step();
    chk("hex_00", 32'(bus.hex_out), 32'hC0C0);
    chk("wrap_pulse", 32'(bus.wrap), 32'h0);

    // BCD carry, borrow wrap and load saturation
    bus.bcd_mode = 1'b1;
    do_load(8'h09);
    wait_tick("tick_bcd_up");
    chk("bcd_09_up", 32'(bus.value), 32'h10);
    chk("bcd_09_wrap", 32'(bus.wrap), 32'h0);
    bus.up = 1'b0;
    do_load(8'h00);
    wait_tick("tick_bcd_dn");
    chk("bcd_00_dn", 32'(bus.value), 32'h99);
    chk("bcd_00_wrap", 32'(bus.wrap), 32'h1);
    step();
    chk("bcd_99_hex", 32'(bus.hex_out), 32'h9090);
    do_load(8'hAB);
    chk("bcd_load_sat", 32'(bus.value), 32'h99);

    // Mode change keeps raw digits; display and arithmetic treat A as 9
    bus.bcd_mode = 1'b0;
    bus.up = 1'b1;
    do_load(8'h3A);
    chk("hex_load_3a", 32'(bus.value), 32'h3A);
    bus.bcd_mode = 1'b1;
    step();
    chk("bcd_disp_a", 32'(bus.hex_out), 32'hB090);
    wait_tick("tick_bcd_a");
    chk("bcd_a_plus1", 32'(bus.value), 32'h40);

    // Leading-zero blanking
    bus.bcd_mode = 1'b0;
    bus.en = 1'b0;
    bus.blank_lz = 1'b1;
    do_load(8'h05);
    step();
    chk("blank_05", 32'(bus.hex_out), 32'hFF92);
    do_load(8'h00);
    step();
    chk("blank_00", 32'(bus.hex_out), 32'hFFC0);
    bus.blank_lz = 1'b0;
    step();
    chk("noblank_00", 32'(bus.hex_out), 32'hC0C0);

    // Enable freeze keeps the prescaler phase
    bus.en = 1'b1;
    do_load(8'h00);
    step();
    step();
    bus.en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("freeze_tick", 32'(bus.tick), 32'h0);
    end
    chk("freeze_value", 32'(bus.value), 32'h00);
    bus.en = 1'b1;
    step();
    chk("resume_no_tick", 32'(bus.tick), 32'h0);
    step();
    chk("resume_tick", 32'(bus.tick), 32'h1);
    chk("resume_value", 32'(bus.value), 32'h01);

    // Asynchronous reset between edges
    bus.en = 1'b0;
    do_load(8'h37);
    step();
    chk("pre_rst_hex", 32'(bus.hex_out), 32'hB0F8);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_value", 32'(bus.value), 32'h00);
    chk("async_rst_hex", 32'(bus.hex_out), 32'hC0C0);
    #1 rst = 1'b0;

    // Load on what would be a tick cycle wins
    step();
    bus.en = 1'b1;
    step();
    step();
    step();
    bus.load = 1'b1;
    bus.load_val = 8'h55;
    step();
    bus.load = 1'b0;
    chk("load_vs_tick_val", 32'(bus.value), 32'h55);
    chk("load_vs_tick_tick", 32'(bus.tick), 32'h0);
    chk("load_vs_tick_wrap", 32'(bus.wrap), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
